// File: rtl/fetch.sv
// Instruction-fetch stage: single-outstanding reads to instruction memory,
// one output slot plus one hold buffer toward decode, redirect squashing.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h80020000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic [31:0] insn,
  output logic [31:0] pc,
  output logic        valid_insn
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] insn_nxt, pc_nxt;
  logic        valid_nxt;
  logic [31:0] hold_insn, hold_insn_nxt;
  logic [31:0] hold_pc, hold_pc_nxt;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus4;
  logic        consume;

  assign redirect_target = {redirect_pc[31:2], 2'b00};
  assign pc_plus4        = fetch_pc + 32'd4;
  assign consume         = valid_insn & ~stall;

  assign im_req  = (state == REQ);
  assign im_addr = fetch_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      fetch_pc   <= RESET_PC;
      insn       <= 32'd0;
      pc         <= 32'd0;
      valid_insn <= 1'b0;
      hold_insn  <= 32'd0;
      hold_pc    <= 32'd0;
    end else begin
      state      <= state_nxt;
      fetch_pc   <= fetch_pc_nxt;
      insn       <= insn_nxt;
      pc         <= pc_nxt;
      valid_insn <= valid_nxt;
      hold_insn  <= hold_insn_nxt;
      hold_pc    <= hold_pc_nxt;
    end
  end

  // The hold buffer is full exactly while in HOLD, so leaving HOLD empties it.
  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    insn_nxt      = insn;
    pc_nxt        = pc;
    valid_nxt     = valid_insn & ~consume;
    hold_insn_nxt = hold_insn;
    hold_pc_nxt   = hold_pc;

    if (redirect) begin
      valid_nxt    = 1'b0;
      fetch_pc_nxt = redirect_target;
      unique case (state)
        REQ:     state_nxt = im_gnt ? DROP : REQ;
        WAIT:    state_nxt = im_rvalid ? REQ : DROP;
        DROP:    state_nxt = im_rvalid ? REQ : DROP;
        default: state_nxt = REQ;
      endcase
    end else begin
      unique case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (im_gnt) state_nxt = WAIT;
        end
        WAIT: begin
          if (im_rvalid) begin
            if (!valid_insn || !stall) begin
              insn_nxt     = im_rdata;
              pc_nxt       = fetch_pc;
              valid_nxt    = 1'b1;
              fetch_pc_nxt = pc_plus4;
              state_nxt    = REQ;
            end else begin
              hold_insn_nxt = im_rdata;
              hold_pc_nxt   = fetch_pc;
              state_nxt     = HOLD;
            end
          end
        end
        DROP: begin
          if (im_rvalid) state_nxt = REQ;
        end
        HOLD: begin
          if (!stall) begin
            insn_nxt     = hold_insn;
            pc_nxt       = hold_pc;
            valid_nxt    = 1'b1;
            fetch_pc_nxt = pc_plus4;
            state_nxt    = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: the bench plays instruction memory cycle by cycle
// and checks the decode-facing outputs against hand-computed values.
module tb_fetch;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic [31:0] insn;
  logic [31:0] pc;
  logic        valid_insn;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] I0  = 32'h24010001;
  localparam logic [31:0] I1  = 32'h24020002;
  localparam logic [31:0] I2  = 32'h24030003;
  localparam logic [31:0] I3  = 32'h24040004;
  localparam logic [31:0] I4  = 32'h8c250010;
  localparam logic [31:0] I5  = 32'hac260014;
  localparam logic [31:0] I6  = 32'h00221820;
  localparam logic [31:0] I7  = 32'h10220005;
  localparam logic [31:0] I8  = 32'h08000100;
  localparam logic [31:0] I9  = 32'h3c01abcd;
  localparam logic [31:0] BAD = 32'hdeadbeef;

  fetch #(.RESET_PC(32'h80020000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .im_req     (im_req),
    .im_addr    (im_addr),
    .im_gnt     (im_gnt),
    .im_rvalid  (im_rvalid),
    .im_rdata   (im_rdata),
    .insn       (insn),
    .pc         (pc),
    .valid_insn (valid_insn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // pc/insn only carry meaning while valid_insn is expected high
  task automatic checkOutput(input string tag, input logic exp_req, input logic [31:0] exp_addr,
                             input logic exp_valid, input logic [31:0] exp_pc,
                             input logic [31:0] exp_insn);
    checkVal({tag, ".im_req"}, {31'd0, im_req}, {31'd0, exp_req});
    checkVal({tag, ".im_addr"}, im_addr, exp_addr);
    checkVal({tag, ".valid"}, {31'd0, valid_insn}, {31'd0, exp_valid});
    if (exp_valid) begin
      checkVal({tag, ".pc"}, pc, exp_pc);
      checkVal({tag, ".insn"}, insn, exp_insn);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc,
                               input logic g, input logic rv, input logic [31:0] rd);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    im_gnt      = g;
    im_rvalid   = rv;
    im_rdata    = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset.insn", insn, 32'd0);
    checkOutput("reset", 1'b0, 32'h80020000, 1'b0, 32'd0, 32'd0);
    checkVal("reset.pc", pc, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle", 1'b0, 32'h80020000, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;

    // Streaming fetch, no stall
    checkOutput("req0", 1'b1, 32'h80020000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("wait0", 1'b0, 32'h80020000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, I0);
    checkOutput("word0", 1'b1, 32'h80020004, 1'b1, 32'h80020000, I0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("wait1", 1'b0, 32'h80020004, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, I1);
    checkOutput("word1", 1'b1, 32'h80020008, 1'b1, 32'h80020004, I1);
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("wait2", 1'b0, 32'h80020008, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, I2);
    checkOutput("word2", 1'b1, 32'h8002000c, 1'b1, 32'h80020008, I2);

    // Stall: output holds I2, I3 parks in the hold buffer
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("stall.wait", 1'b0, 32'h8002000c, 1'b1, 32'h80020008, I2);
    applyStimulus(1, 0, 0, 0, 1, I3);
    checkOutput("stall.hold", 1'b0, 32'h8002000c, 1'b1, 32'h80020008, I2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("stall.keep", 1'b0, 32'h8002000c, 1'b1, 32'h80020008, I2);
    end
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("stall.release", 1'b1, 32'h80020010, 1'b1, 32'h8002000c, I3);

    // Redirect while waiting: response dropped, target fetched word-aligned
    applyStimulus(0, 0, 0, 1, 0, 0);
    checkOutput("rdw.wait", 1'b0, 32'h80020010, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 1, 32'h80021003, 0, 0, 0);
    checkOutput("rdw.drop", 1'b0, 32'h80021000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, BAD);
    checkOutput("rdw.req", 1'b1, 32'h80021000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, I4);
    checkOutput("rdw.word", 1'b1, 32'h80021004, 1'b1, 32'h80021000, I4);

    // Redirect coincident with rvalid while stalled: word and slot squashed
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("rdv.wait", 1'b0, 32'h80021004, 1'b1, 32'h80021000, I4);
    applyStimulus(1, 1, 32'h80030000, 0, 1, I5);
    checkOutput("rdv.squash", 1'b1, 32'h80030000, 1'b0, 32'd0, 32'd0);
    applyStimulus(1, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, I6);
    checkOutput("rdv.word", 1'b1, 32'h80030004, 1'b1, 32'h80030000, I6);

    // Redirect to top of memory while ungranted in REQ, then wrap
    applyStimulus(0, 1, 32'hfffffffe, 0, 0, 0);
    checkOutput("wrap.req", 1'b1, 32'hfffffffc, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, I7);
    checkOutput("wrap.top", 1'b1, 32'h00000000, 1'b1, 32'hfffffffc, I7);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, I8);
    checkOutput("wrap.zero", 1'b1, 32'h00000004, 1'b1, 32'h00000000, I8);

    // Redirect with grant in REQ, then a second redirect while dropping
    applyStimulus(0, 1, 32'h80040000, 1, 0, 0);
    checkOutput("drop.enter", 1'b0, 32'h80040000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 1, 32'h80050008, 0, 0, 0);
    checkOutput("drop.reload", 1'b0, 32'h80050008, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("drop.stay", 1'b0, 32'h80050008, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, BAD);
    checkOutput("drop.exit", 1'b1, 32'h80050008, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, I9);
    checkOutput("drop.word", 1'b1, 32'h8005000c, 1'b1, 32'h80050008, I9);

    // Asynchronous reset while in WAIT with a live word, stale response after release
    applyStimulus(1, 0, 0, 1, 0, 0);
    checkOutput("rst.wait", 1'b0, 32'h8005000c, 1'b1, 32'h80050008, I9);
    rst_n = 1'b0;
    stall = 1'b0; im_gnt = 1'b0;
    #2;
    checkOutput("rst.async", 1'b0, 32'h80020000, 1'b0, 32'd0, 32'd0);
    checkVal("rst.async.pc", pc, 32'd0);
    checkVal("rst.async.insn", insn, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    im_rvalid = 1'b1;
    im_rdata  = BAD;
    @(posedge clk);
    #1;
    checkOutput("rst.req", 1'b1, 32'h80020000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 0, 1, BAD);
    checkOutput("rst.stale", 1'b1, 32'h80020000, 1'b0, 32'd0, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, I0);
    checkOutput("rst.word", 1'b1, 32'h80020004, 1'b1, 32'h80020000, I0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
